// File: rtl/mem_system.sv
// mem_system: word-addressed text/data RAM plus an optional console TX FIFO.
//
// Address map (bits[1:0] of memaddress ignored for decode):
//   TEXT      0x00400000 + 4*i, i < TEXT_WORDS
//   DATA      0x10010000 + 4*i, i < DATA_WORDS
//   CON_TX    0xFFFF0000  (console build only)
//   CON_STAT  0xFFFF0004  (console build only)
//   anything else is unmapped: reads return 0xDEADBEEF, writes are dropped,
//   and the first such access latches fault/fault_addr until reset.
//
// Build option: define MEM_SYSTEM_CONSOLE_EN to include the console FIFO.
// Without it, the console addresses are unmapped, con_valid/con_data are
// tied to 0 and con_ready is ignored.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   memop       0 idle, 1 read, 2 write, other values idle
//   memaddress  byte address of the request
//   memoutdata  write data
//   memindata   read data, combinational from memaddress while memop==1
//   con_data    console byte at FIFO head
//   con_valid   FIFO non-empty
//   con_ready   host accepts con_data this edge
//   fault       sticky unmapped-access flag
//   fault_addr  address of the first unmapped access
module mem_system #(
    parameter int TEXT_WORDS = 1024,
    parameter int DATA_WORDS = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memop,
    input  logic [31:0] memaddress,
    input  logic [31:0] memoutdata,
    output logic [31:0] memindata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        fault,
    output logic [31:0] fault_addr
);
    localparam logic [31:0] TEXT_BASE      = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE      = 32'h1001_0000;
    localparam logic [29:0] CON_TX_WADDR   = 30'h3FFF_C000;
    localparam logic [29:0] CON_STAT_WADDR = 30'h3FFF_C001;
    localparam logic [31:0] TEXT_LIM       = 32'(TEXT_WORDS);
    localparam logic [31:0] DATA_LIM       = 32'(DATA_WORDS);
    localparam int          TAW            = (TEXT_WORDS > 1) ? $clog2(TEXT_WORDS) : 1;
    localparam int          DAW            = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    logic [31:0] text_ram [TEXT_WORDS];
    logic [31:0] data_ram [DATA_WORDS];

    logic        is_rd;
    logic        is_wr;
    logic [31:0] text_off;
    logic [31:0] data_off;
    logic        hit_text;
    logic        hit_data;
    logic        hit_tx;
    logic        hit_stat;
    logic        unmapped_acc;
    logic [31:0] stat_word;

    assign is_rd = (memop == 32'd1);
    assign is_wr = (memop == 32'd2);

    // Subtracting the base makes addresses below it wrap to huge offsets,
    // so a single upper-bound compare covers both ends of each region.
    assign text_off = memaddress - TEXT_BASE;
    assign data_off = memaddress - DATA_BASE;
    assign hit_text = (text_off >> 2) < TEXT_LIM;
    assign hit_data = (data_off >> 2) < DATA_LIM;

    assign unmapped_acc = (is_rd | is_wr) & ~(hit_text | hit_data | hit_tx | hit_stat);

    always_comb begin
        memindata = '0;
        if (is_rd) begin
            if (hit_text)      memindata = text_ram[text_off[TAW+1:2]];
            else if (hit_data) memindata = data_ram[data_off[DAW+1:2]];
            else if (hit_tx)   memindata = '0;
            else if (hit_stat) memindata = stat_word;
            else               memindata = 32'hDEAD_BEEF;
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (is_wr && hit_text) text_ram[text_off[TAW+1:2]] <= memoutdata;
        if (is_wr && hit_data) data_ram[data_off[DAW+1:2]] <= memoutdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (unmapped_acc && !fault) begin
            fault      <= 1'b1;
            fault_addr <= memaddress;
        end
    end

`ifdef MEM_SYSTEM_CONSOLE_EN
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [3:0]    count_lo;
    logic          overflow;
    logic          prev_wr;
    logic          first_wr;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;

    assign hit_tx   = (memaddress[31:2] == CON_TX_WADDR);
    assign hit_stat = (memaddress[31:2] == CON_STAT_WADDR);

    // A held write only acts on its first edge so a stalled requester
    // does not flood the console.
    assign first_wr = is_wr && !prev_wr;
    assign push_req = first_wr && hit_tx;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop      = con_valid && con_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full || pop);

    assign count_lo  = 4'(count);
    assign stat_word = {20'b0, count_lo, 5'b0, overflow, empty, full};
    assign con_valid = !empty;
    assign con_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            prev_wr  <= 1'b0;
        end else begin
            prev_wr <= is_wr;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop)   overflow <= 1'b1;
            else if (first_wr && hit_stat)  overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= memoutdata[7:0];
    end
`else
    logic unused_con;

    assign hit_tx     = 1'b0;
    assign hit_stat   = 1'b0;
    assign stat_word  = '0;
    assign con_valid  = 1'b0;
    assign con_data   = '0;
    assign unused_con = con_ready;
`endif

endmodule

// File: tb/tb_mem_system.sv
`timescale 1ns/1ps
module tb_mem_system;
    localparam int TW = 1024;
    localparam int DW = 1024;
    localparam int FD = 8;
`ifdef MEM_SYSTEM_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memop = '0;
    logic [31:0] memaddress = '0;
    logic [31:0] memoutdata = '0;
    logic        con_ready = 1'b0;
    logic [31:0] memindata;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        fault;
    logic [31:0] fault_addr;

    mem_system #(.TEXT_WORDS(TW), .DATA_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .memop(memop), .memaddress(memaddress),
        .memoutdata(memoutdata), .memindata(memindata), .con_data(con_data),
        .con_valid(con_valid), .con_ready(con_ready), .fault(fault),
        .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_text [int];
    logic [31:0] m_data [int];
    logic [7:0]  m_q [$];
    bit          m_ovf = 1'b0;
    bit          m_fault = 1'b0;
    bit          m_prev_wr = 1'b0;
    logic [31:0] m_faddr = '0;

    // 0 unmapped, 1 text, 2 data, 3 con_tx, 4 con_stat
    function automatic int region(input logic [31:0] a, output int idx);
        longint w;
        w = longint'({a[31:2], 2'b00});
        idx = 0;
        if (w >= 64'h0040_0000 && w < 64'h0040_0000 + 4 * TW) begin
            idx = int'((w - 64'h0040_0000) / 4);
            return 1;
        end
        if (w >= 64'h1001_0000 && w < 64'h1001_0000 + 4 * DW) begin
            idx = int'((w - 64'h1001_0000) / 4);
            return 2;
        end
        if (CON_EN && w == 64'hFFFF_0000) return 3;
        if (CON_EN && w == 64'hFFFF_0004) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] m_stat();
        int c;
        c = m_q.size();
        return (32'(c % 16) << 8) | (m_ovf ? 32'd4 : 32'd0)
             | (c == 0 ? 32'd2 : 32'd0) | (c == FD ? 32'd1 : 32'd0);
    endfunction

    function automatic void m_read(input logic [31:0] op, input logic [31:0] a,
                                   output logic [31:0] v, output bit known);
        int idx, r;
        v = '0;
        known = 1'b1;
        if (op != 32'd1) return;
        r = region(a, idx);
        case (r)
            1: if (m_text.exists(idx)) v = m_text[idx]; else known = 1'b0;
            2: if (m_data.exists(idx)) v = m_data[idx]; else known = 1'b0;
            3: v = '0;
            4: v = m_stat();
            default: v = 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_fault   = 1'b0;
            m_faddr   = '0;
            m_prev_wr = 1'b0;
        end else begin
            int idx, r;
            bit wr, rd, first, pop, push;
            r     = region(memaddress, idx);
            wr    = (memop == 32'd2);
            rd    = (memop == 32'd1);
            first = wr && !m_prev_wr;
            if ((wr || rd) && r == 0 && !m_fault) begin
                m_fault = 1'b1;
                m_faddr = memaddress;
            end
            if (wr && r == 1) m_text[idx] = memoutdata;
            if (wr && r == 2) m_data[idx] = memoutdata;
            pop  = (m_q.size() != 0) && con_ready;
            push = first && r == 3;
            if (first && r == 4) m_ovf = 1'b0;
            if (push && m_q.size() == FD && !pop) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push && m_q.size() < FD) m_q.push_back(memoutdata[7:0]);
            m_prev_wr = wr;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_on) begin
            logic [31:0] ev;
            bit known;
            m_read(memop, memaddress, ev, known);
            if (known) chk("memindata", memindata, ev);
            chk("con_valid", 32'(con_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("con_data", 32'(con_data), 32'(m_q[0]));
`ifndef MEM_SYSTEM_CONSOLE_EN
            chk("con_data_tied", 32'(con_data), 32'd0);
`endif
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_addr", fault_addr, m_faddr);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] op, input logic [31:0] a, input logic [31:0] d);
        memop = op;
        memaddress = a;
        memoutdata = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drv(32'd2, a, d);
        step();
        drv(32'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drv(32'd1, a, 32'd0);
        #1;
        chk(name, memindata, exp);
        step();
        drv(32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] addrs [8];
        addrs = '{32'h0040_0000, 32'h0040_0004, 32'h1001_0000, 32'h1001_0008,
                  32'hFFFF_0000, 32'hFFFF_0004, 32'h2000_0000, 32'h0040_0FFC};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_con_valid", 32'(con_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_memindata_idle", memindata, 32'd0);
        drv(32'd1, 32'h2000_0000, 32'd0);
        #1;
        chk("rst_memindata_comb", memindata, 32'hDEAD_BEEF);
        drv(32'd0, 32'd0, 32'd0);
        step();
        rst = 1'b0;
        model_on = 1'b1;

        drv(32'd3, 32'h2000_0000, 32'd0);
        #1;
        chk("op3_memindata", memindata, 32'd0);
        step();
        drv(32'd0, 32'd0, 32'd0);
        chk("op3_no_fault", 32'(fault), 32'd0);

        wr(32'h1001_0010, 32'h1234_5678);
        rd_chk("data_rd", 32'h1001_0010, 32'h1234_5678);
        rd_chk("data_rd_lowbits", 32'h1001_0013, 32'h1234_5678);
        wr(32'h0040_0000, 32'hCAFE_F00D);
        wr(32'h0040_0FFC, 32'h1111_2222);
        wr(32'h1001_0FFC, 32'h3333_4444);
        rd_chk("text_first", 32'h0040_0000, 32'hCAFE_F00D);
        rd_chk("text_last", 32'h0040_0FFC, 32'h1111_2222);
        rd_chk("data_last", 32'h1001_0FFC, 32'h3333_4444);
        drv(32'd2, 32'h1001_0020, 32'h55AA_55AA);
        repeat (3) step();
        drv(32'd0, 32'd0, 32'd0);
        rd_chk("data_held_wr", 32'h1001_0020, 32'h55AA_55AA);

`ifdef MEM_SYSTEM_CONSOLE_EN
        con_ready = 1'b0;
        drv(32'd2, 32'hFFFF_0000, 32'h0000_0041);
        repeat (3) step();
        drv(32'd0, 32'd0, 32'd0);
        chk("tx_held_valid", 32'(con_valid), 32'd1);
        chk("tx_held_data", 32'(con_data), 32'h41);
        rd_chk("stat_one", 32'hFFFF_0004, 32'h0000_0100);
        rd_chk("tx_read_zero", 32'hFFFF_0000, 32'd0);
        con_ready = 1'b1;
        step();
        con_ready = 1'b0;
        chk("drained_valid", 32'(con_valid), 32'd0);
        rd_chk("stat_empty", 32'hFFFF_0004, 32'h0000_0002);
        for (int i = 0; i < 9; i++) wr(32'hFFFF_0000, 32'h30 + 32'(i));
        rd_chk("stat_full_ovf", 32'hFFFF_0004, 32'h0000_0805);
        chk("full_head", 32'(con_data), 32'h30);
        wr(32'hFFFF_0004, 32'd0);
        rd_chk("stat_ovf_clr", 32'hFFFF_0004, 32'h0000_0801);
        con_ready = 1'b1;
        drv(32'd2, 32'hFFFF_0000, 32'h0000_0099);
        step();
        con_ready = 1'b0;
        drv(32'd0, 32'd0, 32'd0);
        rd_chk("stat_push_pop_full", 32'hFFFF_0004, 32'h0000_0801);
        chk("push_pop_head", 32'(con_data), 32'h31);
        con_ready = 1'b1;
        repeat (7) step();
        chk("tail_byte", 32'(con_data), 32'h99);
        step();
        con_ready = 1'b0;
        chk("drain_all", 32'(con_valid), 32'd0);
`endif

        rd_chk("unmapped_rd", 32'h2000_0000, 32'hDEAD_BEEF);
        wr(32'h3000_0000, 32'h0000_0001);
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_addr_first", fault_addr, 32'h2000_0000);
        rd_chk("unmapped_rd2", 32'h3000_0000, 32'hDEAD_BEEF);
        chk("fault_addr_sticky", fault_addr, 32'h2000_0000);

`ifdef MEM_SYSTEM_CONSOLE_EN
        wr(32'hFFFF_0000, 32'h0000_0055);
        chk("pre_rst_valid", 32'(con_valid), 32'd1);
`endif
        drv(32'd1, 32'h1001_0010, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(con_valid), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        chk("async_rst_faddr", fault_addr, 32'd0);
        chk("rst_rd_comb", memindata, 32'h1234_5678);
        step();
        step();
        rst = 1'b0;
        drv(32'd0, 32'd0, 32'd0);
        rd_chk("ram_kept_data", 32'h1001_0010, 32'h1234_5678);
        rd_chk("ram_kept_text", 32'h0040_0FFC, 32'h1111_2222);

        rd_chk("text_past_end", 32'h0040_1000, 32'hDEAD_BEEF);
        chk("fault_addr_bound", fault_addr, 32'h0040_1000);
        rd_chk("data_past_end", 32'h1001_1000, 32'hDEAD_BEEF);
        chk("fault_addr_kept", fault_addr, 32'h0040_1000);
`ifndef MEM_SYSTEM_CONSOLE_EN
        rd_chk("stat_unmapped", 32'hFFFF_0004, 32'hDEAD_BEEF);
`endif

        for (int i = 0; i < 300; i++) begin
            drv(32'($urandom_range(0, 3)), addrs[$urandom_range(0, 7)], $urandom);
            con_ready = 1'($urandom_range(0, 1));
            step();
        end
        drv(32'd0, 32'd0, 32'd0);
        con_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
